// File: rtl/htif_mem_arbiter.sv
// htif_mem_arbiter
//   Shares the single HTIF-side memory request/response port between two
//   requesters (req0 = HTIF, req1 = secondary agent such as scan/debug DMA).
//   Requests are arbitrated round-robin into a single registered request
//   stage. The MSB of the memory-side tag records which requester issued the
//   request, and responses are routed back using that bit. Reads in flight
//   are counted per requester. A response that arrives for a requester with
//   no reads outstanding sets a sticky error flag.
//
//   Optional feature macro: ARB_OUTSTANDING_LIMIT_EN
//     defined   : a requester with MAX_OUTSTANDING reads in flight is masked
//                 from arbitration, for reads and writes alike, until one of
//                 its responses returns.
//     undefined : no masking. The counters only feed the error check.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   reqN_val/rdy                request handshake, N = 0,1
//   reqN_rw/addr/data/tag       request fields (rw=1 write, 0 read)
//   respN_val/data/tag          routed response, one cycle after mem_resp
//   mem_req_val/rdy             registered memory request handshake
//   mem_req_rw/addr/data/tag    registered request fields, tag = {src, tag}
//   mem_resp_val/data/tag       memory response, tag MSB selects requester
//   error                       sticky orphan-response flag
module htif_mem_arbiter #(
  parameter int TAG_BITS        = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                req0_val,
  output logic                req0_rdy,
  input  logic                req0_rw,
  input  logic [31:0]         req0_addr,
  input  logic [127:0]        req0_data,
  input  logic [TAG_BITS-1:0] req0_tag,

  input  logic                req1_val,
  output logic                req1_rdy,
  input  logic                req1_rw,
  input  logic [31:0]         req1_addr,
  input  logic [127:0]        req1_data,
  input  logic [TAG_BITS-1:0] req1_tag,

  output logic                resp0_val,
  output logic [127:0]        resp0_data,
  output logic [TAG_BITS-1:0] resp0_tag,

  output logic                resp1_val,
  output logic [127:0]        resp1_data,
  output logic [TAG_BITS-1:0] resp1_tag,

  output logic                mem_req_val,
  input  logic                mem_req_rdy,
  output logic                mem_req_rw,
  output logic [31:0]         mem_req_addr,
  output logic [127:0]        mem_req_data,
  output logic [TAG_BITS:0]   mem_req_tag,

  input  logic                mem_resp_val,
  input  logic [127:0]        mem_resp_data,
  input  logic [TAG_BITS:0]   mem_resp_tag,

  output logic                error
);

  localparam int CW = $clog2(2**TAG_BITS + 1);

  logic [CW-1:0] cnt0, cnt1;
  logic          elig0, elig1;
  logic          grant0, grant1;
  logic          load_en, accept;
  logic          last_is1;
  logic          rd0, rd1, rsp0, rsp1, dec0, dec1, orphan;
  logic [127:0]  resp_data_q;
  logic [TAG_BITS-1:0] resp_tag_q;

`ifdef ARB_OUTSTANDING_LIMIT_EN
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
  assign elig0 = req0_val && (cnt0 != CNT_MAX);
  assign elig1 = req1_val && (cnt1 != CNT_MAX);
`else
  // The read cap has no effect in this build. The parameter stays so that
  // both builds share one interface.
  logic unused_max_outstanding;
  assign unused_max_outstanding = (MAX_OUTSTANDING > 0);
  assign elig0 = req0_val;
  assign elig1 = req1_val;
`endif

  // The stage accepts a new request when it is empty or when its current
  // request drains in the same cycle.
  assign load_en = !mem_req_val || mem_req_rdy;

  // When both requesters are eligible, the one not granted last wins.
  // last_is1 resets to 1, so req0 wins the first tie after reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && (!elig1 || last_is1))
      grant0 = 1'b1;
    else if (elig1)
      grant1 = 1'b1;
  end

  assign req0_rdy = grant0 && load_en;
  assign req1_rdy = grant1 && load_en;
  assign accept   = req0_rdy || req1_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_val  <= 1'b0;
      mem_req_rw   <= 1'b0;
      mem_req_addr <= '0;
      mem_req_data <= '0;
      mem_req_tag  <= '0;
      last_is1     <= 1'b1;
    end else if (load_en) begin
      mem_req_val <= accept;
      if (req0_rdy) begin
        mem_req_rw   <= req0_rw;
        mem_req_addr <= req0_addr;
        mem_req_data <= req0_data;
        mem_req_tag  <= {1'b0, req0_tag};
        last_is1     <= 1'b0;
      end else if (req1_rdy) begin
        mem_req_rw   <= req1_rw;
        mem_req_addr <= req1_addr;
        mem_req_data <= req1_data;
        mem_req_tag  <= {1'b1, req1_tag};
        last_is1     <= 1'b1;
      end
    end
  end

  assign rd0  = req0_rdy && !req0_rw;
  assign rd1  = req1_rdy && !req1_rw;
  assign rsp0 = mem_resp_val && !mem_resp_tag[TAG_BITS];
  assign rsp1 = mem_resp_val &&  mem_resp_tag[TAG_BITS];
  // A count already at zero is never decremented. Such a response is an
  // orphan and is still forwarded to its requester.
  assign dec0   = rsp0 && (cnt0 != '0);
  assign dec1   = rsp1 && (cnt1 != '0);
  assign orphan = (rsp0 && (cnt0 == '0)) || (rsp1 && (cnt1 == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0  <= '0;
      cnt1  <= '0;
      error <= 1'b0;
    end else begin
      case ({rd0, dec0})
        2'b10:   cnt0 <= cnt0 + CW'(1);
        2'b01:   cnt0 <= cnt0 - CW'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({rd1, dec1})
        2'b10:   cnt1 <= cnt1 + CW'(1);
        2'b01:   cnt1 <= cnt1 - CW'(1);
        default: cnt1 <= cnt1;
      endcase
      if (orphan)
        error <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp0_val   <= 1'b0;
      resp1_val   <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      resp0_val <= rsp0;
      resp1_val <= rsp1;
      if (mem_resp_val) begin
        resp_data_q <= mem_resp_data;
        resp_tag_q  <= mem_resp_tag[TAG_BITS-1:0];
      end
    end
  end

  // Only one respN_val is ever high, so both requesters share the data/tag register.
  assign resp0_data = resp_data_q;
  assign resp1_data = resp_data_q;
  assign resp0_tag  = resp_tag_q;
  assign resp1_tag  = resp_tag_q;

endmodule
